malu_modexp_seq: RTL and testbench



---
 rtl/malu_modexp_seq.sv | 198 +++++++++++++++++++
 tb/tb_malu_modexp_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/malu_modexp_seq.sv
// Modular-exponentiation sequencer in front of the MALU.
// Computes base^exp mod m by right-to-left square-and-multiply: one MALU
// multiply/reduce per step, with the combinational result captured on the
// same clock edge. All outputs, including the MALU operand bus, are registered
// and are loaded from the next-state values.
module malu_modexp_seq #(
  parameter int unsigned EXP_W  = 128,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned MOD_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] base_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MOD_W-1:0]  mod_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] malu_a,
  output logic [DATA_W-1:0] malu_b,
  output logic [MOD_W-1:0]  malu_c,
  output logic [2:0]        malu_op,
  input  logic [DATA_W-1:0] malu_result
);

  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_MOD  = 3'b011;
  localparam logic [2:0] OP_IDLE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REDUCE = 3'd1,
    S_INIT   = 3'd2,
    S_MUL    = 3'd3,
    S_SQR    = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [EXP_W-1:0]    e_q, e_d;
  logic [MOD_W-1:0]    m_q, m_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   malu_a_q, malu_a_d;
  logic [DATA_W-1:0]   malu_b_q, malu_b_d;
  logic [MOD_W-1:0]    malu_c_q, malu_c_d;
  logic [2:0]          malu_op_q, malu_op_d;

  // Step selection from the remaining exponent bits.
  function automatic state_t step_for(input logic [EXP_W-1:0] e);
    if (e == '0)      return S_FIN;
    else if (e[0])    return S_MUL;
    else              return S_SQR;
  endfunction

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      b_q       <= '0;
      e_q       <= '0;
      m_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
      malu_a_q  <= '0;
      malu_b_q  <= '0;
      malu_c_q  <= '0;
      malu_op_q <= OP_IDLE;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      e_q       <= e_d;
      m_q       <= m_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
      malu_a_q  <= malu_a_d;
      malu_b_q  <= malu_b_d;
      malu_c_q  <= malu_c_d;
      malu_op_q <= malu_op_d;
    end
  end

  // Next-state, datapath capture and the operand bus for the next step.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    b_d       = b_q;
    e_d       = e_q;
    m_d       = m_q;
    err_d     = err_q;
    result_d  = result_q;
    malu_a_d  = '0;
    malu_b_d  = '0;
    malu_c_d  = '0;
    malu_op_d = OP_IDLE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d   = base_in;
          e_d   = exp_in;
          m_d   = mod_in;
          err_d = 1'b0;
          if (mod_in == '0) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_REDUCE;
          end
        end
      end
      S_REDUCE: begin
        b_d     = malu_result;
        state_d = S_INIT;
      end
      S_INIT: begin
        acc_d   = malu_result;
        state_d = step_for(e_q);
      end
      S_MUL: begin
        acc_d   = malu_result;
        state_d = S_SQR;
      end
      S_SQR: begin
        b_d     = malu_result;
        e_d     = e_q >> 1;
        state_d = step_for(e_q >> 1);
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result becomes visible together with the done pulse.
    if (state_d == S_FIN) begin
      result_d = err_d ? '0 : acc_d;
    end

    done_d = (state_d == S_FIN);
    busy_d = (state_d == S_REDUCE) || (state_d == S_INIT) ||
             (state_d == S_MUL)    || (state_d == S_SQR);

    case (state_d)
      S_REDUCE: begin
        malu_op_d = OP_MOD;
        malu_a_d  = b_d;
        malu_b_d  = DATA_W'(m_d);
        malu_c_d  = m_d;
      end
      S_INIT: begin
        malu_op_d = OP_MOD;
        malu_a_d  = DATA_W'(1);
        malu_b_d  = DATA_W'(m_d);
        malu_c_d  = m_d;
      end
      S_MUL: begin
        malu_op_d = OP_MUL;
        malu_a_d  = acc_d;
        malu_b_d  = b_d;
        malu_c_d  = m_d;
      end
      S_SQR: begin
        malu_op_d = OP_MUL;
        malu_a_d  = b_d;
        malu_b_d  = b_d;
        malu_c_d  = m_d;
      end
      default: begin
        malu_op_d = OP_IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign result  = result_q;
  assign malu_a  = malu_a_q;
  assign malu_b  = malu_b_q;
  assign malu_c  = malu_c_q;
  assign malu_op = malu_op_q;

endmodule

// File: tb/tb_malu_modexp_seq.sv
// Directed testbench for malu_modexp_seq with a behavioural MALU attached.
module tb_malu_modexp_seq;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] base_in;
  logic [127:0] exp_in;
  logic [5:0]   mod_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] result;
  logic [127:0] malu_a;
  logic [127:0] malu_b;
  logic [5:0]   malu_c;
  logic [2:0]   malu_op;
  logic [127:0] malu_result;

  int errors = 0;
  int checks = 0;
  int cyc;
  int busy_cnt;
  int n_mod;
  int n_mul;

  malu_modexp_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_in    (base_in),
    .exp_in     (exp_in),
    .mod_in     (mod_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .malu_a     (malu_a),
    .malu_b     (malu_b),
    .malu_c     (malu_c),
    .malu_op    (malu_op),
    .malu_result(malu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MALU: 010 = (A*B) mod C, 011 = A mod B, otherwise 0.
  always_comb begin
    case (malu_op)
      3'b010:  malu_result = (malu_c == 6'd0) ? 128'd0 : (malu_a * malu_b) % {122'd0, malu_c};
      3'b011:  malu_result = (malu_b == 128'd0) ? 128'd0 : malu_a % malu_b;
      default: malu_result = 128'd0;
    endcase
  end

  task automatic issue(input logic [127:0] b, input logic [127:0] e, input logic [5:0] m);
    @(negedge clk);
    start   = 1'b1;
    base_in = b;
    exp_in  = e;
    mod_in  = m;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, counting cycles and the ops seen; returns at the done-cycle negedge.
  task automatic wait_done(input int budget);
    bit got;
    got = 0;
    cyc = 0; busy_cnt = 0; n_mod = 0; n_mul = 0;
    while (cyc < budget && !got) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (malu_op == 3'b011) n_mod++;
      if (malu_op == 3'b010) n_mul++;
      if (done) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_in = '0; exp_in = '0; mod_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
    checks++; if (result !== 128'd0)  begin errors++; $display("FAIL rst_result: got %0d want 0", result); end
    checks++; if (malu_op !== 3'b111) begin errors++; $display("FAIL rst_op: got %b want 111", malu_op); end
    checks++; if (malu_a !== 128'd0 || malu_b !== 128'd0 || malu_c !== 6'd0)
      begin errors++; $display("FAIL rst_operands: got a=%0d b=%0d c=%0d want 0", malu_a, malu_b, malu_c); end
  endtask

  task automatic test_basic();
    issue(128'd4, 128'd13, 6'd17);
    wait_done(40);
    checks++; if (result !== 128'd4) begin errors++; $display("FAIL basic_result: got %0d want 4", result); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL basic_err: got %0b want 0", err); end
    checks++; if (cyc != 10)         begin errors++; $display("FAIL basic_latency: got %0d want 10", cyc); end
    checks++; if (busy_cnt != 9)     begin errors++; $display("FAIL basic_busy_cycles: got %0d want 9", busy_cnt); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL basic_busy_at_done: got %0b want 0", busy); end
    checks++; if (malu_op !== 3'b111) begin errors++; $display("FAIL basic_fin_op: got %b want 111", malu_op); end
    @(negedge clk);
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL basic_done_pulse: got %0b want 0", done); end
    checks++; if (result !== 128'd4) begin errors++; $display("FAIL basic_result_held: got %0d want 4", result); end
  endtask

  task automatic test_small_cases();
    issue(128'd7, 128'd0, 6'd10);
    wait_done(20);
    checks++; if (result !== 128'd1) begin errors++; $display("FAIL exp0_result: got %0d want 1", result); end
    checks++; if (cyc != 3)          begin errors++; $display("FAIL exp0_latency: got %0d want 3", cyc); end
    checks++; if (n_mul != 0 || n_mod != 2)
      begin errors++; $display("FAIL exp0_ops: got mul=%0d mod=%0d want mul=0 mod=2", n_mul, n_mod); end
    issue(128'd5, 128'd3, 6'd1);
    wait_done(20);
    checks++; if (result !== 128'd0) begin errors++; $display("FAIL mod1_result: got %0d want 0", result); end
    checks++; if (cyc != 7)          begin errors++; $display("FAIL mod1_latency: got %0d want 7", cyc); end
  endtask

  task automatic test_full_exponent();
    logic [127:0] ones;
    ones = {128{1'b1}};
    issue(128'd2, ones, 6'd63);
    wait_done(400);
    checks++; if (result !== 128'd8) begin errors++; $display("FAIL full_result: got %0d want 8", result); end
    checks++; if (cyc != 259)        begin errors++; $display("FAIL full_latency: got %0d want 259", cyc); end
    checks++; if (busy_cnt != 258)   begin errors++; $display("FAIL full_busy_cycles: got %0d want 258", busy_cnt); end
    checks++; if (n_mod != 2 || n_mul != 256)
      begin errors++; $display("FAIL full_op_seq: got mod=%0d mul=%0d want mod=2 mul=256", n_mod, n_mul); end
  endtask

  task automatic test_mod_zero();
    issue(128'd9, 128'd5, 6'd0);
    @(negedge clk);
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL mod0_done: got %0b want 1", done); end
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL mod0_err: got %0b want 1", err); end
    checks++; if (result !== 128'd0)  begin errors++; $display("FAIL mod0_result: got %0d want 0", result); end
    checks++; if (malu_op !== 3'b111) begin errors++; $display("FAIL mod0_op: got %b want 111", malu_op); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mod0_busy: got %0b want 0", busy); end
    @(negedge clk);
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL mod0_err_held: got %0b want 1", err); end
    issue(128'd3, 128'd4, 6'd5);
    wait_done(30);
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL mod0_err_clear: got %0b want 0", err); end
    checks++; if (result !== 128'd1)  begin errors++; $display("FAIL mod0_next_result: got %0d want 1", result); end
    checks++; if (cyc != 7)           begin errors++; $display("FAIL mod0_next_latency: got %0d want 7", cyc); end
  endtask

  task automatic test_start_while_busy();
    issue(128'd4, 128'd13, 6'd17);
    repeat (3) @(negedge clk);
    start = 1'b1; base_in = 128'd3; exp_in = 128'd5; mod_in = 6'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(30);
    checks++; if (result !== 128'd4) begin errors++; $display("FAIL busy_ignore_result: got %0d want 4", result); end
    checks++; if (cyc != 6)          begin errors++; $display("FAIL busy_ignore_latency: got %0d want 6", cyc); end
  endtask

  task automatic test_back_to_back();
    issue(128'd4, 128'd13, 6'd17);
    wait_done(40);
    start = 1'b1; base_in = 128'd3; exp_in = 128'd3; mod_in = 6'd11;
    @(negedge clk);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL b2b_done_cycle_ignored: busy got %0b want 0", busy); end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(30);
    checks++; if (result !== 128'd5) begin errors++; $display("FAIL b2b_result: got %0d want 5", result); end
    checks++; if (cyc != 7)          begin errors++; $display("FAIL b2b_latency: got %0d want 7", cyc); end
  endtask

  task automatic test_reset_mid_op();
    issue(128'd4, 128'd13, 6'd17);
    repeat (4) @(negedge clk);
    checks++; if (malu_op !== 3'b010 || malu_a !== 128'd4 || malu_b !== 128'd4)
      begin errors++; $display("FAIL midop_sqr: got op=%b a=%0d b=%0d want op=010 a=4 b=4", malu_op, malu_a, malu_b); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL midrst_flags: got busy=%0b done=%0b want 0 0", busy, done); end
    checks++; if (result !== 128'd0)  begin errors++; $display("FAIL midrst_result: got %0d want 0", result); end
    checks++; if (malu_op !== 3'b111) begin errors++; $display("FAIL midrst_op: got %b want 111", malu_op); end
    issue(128'd2, 128'd5, 6'd13);
    wait_done(30);
    checks++; if (result !== 128'd6)  begin errors++; $display("FAIL midrst_fresh_result: got %0d want 6", result); end
    checks++; if (cyc != 8)           begin errors++; $display("FAIL midrst_fresh_latency: got %0d want 8", cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_cases();
    test_full_exponent();
    test_mod_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
